// File: rtl/bundle_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : bundle_accumulator_if
// Description : Core-array to bundle accumulator connection. The master side
//               drives the per-core strobes and result bits. The slave side
//               returns the majority sign, the accumulator, the store count
//               and the status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface bundle_accumulator_if #(
    parameter int W       = 30,
    parameter int CORENUM = 16
);
    logic               clear;
    logic [CORENUM-1:0] store;
    logic [CORENUM-1:0] core_result;
    logic               tie_bit;
    logic               sign_bit;
    logic [W-1:0]       acc_value;
    logic [W-1:0]       store_count;
    logic               busy;
    logic               sat_flag;

    modport master (
        output clear, store, core_result, tie_bit,
        input  sign_bit, acc_value, store_count, busy, sat_flag
    );

    modport slave (
        input  clear, store, core_result, tie_bit,
        output sign_bit, acc_value, store_count, busy, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/bundle_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : bundle_accumulator
// Description : Three-stage bundling accumulator. Strobed core result bits map
//               to +1/-1, are summed across lanes and accumulated into a
//               saturating signed register. sign_bit is the bundled
//               hypervector bit. Optional macro BUNDLE_TIE_BREAK_EN drives
//               sign_bit from tie_bit when the accumulator is exactly zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bundle_accumulator #(
    parameter int W       = 30,
    parameter int CORENUM = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bundle_accumulator_if.slave  bus
);
    // Lane sum width: holds [-CORENUM, +CORENUM]
    localparam int SW = $clog2(CORENUM + 1) + 1;
    // Wide enough that acc + sum can never wrap before the clamp decision
    localparam int XW = W + SW;

    localparam logic signed [XW-1:0] c_ACC_MAX = {{(SW + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [XW-1:0] c_ACC_MIN = {{(SW + 1){1'b1}}, {(W - 1){1'b0}}};
    localparam logic [W-1:0]         c_CNT_MAX = '1;

    logic signed [1:0]    r_sel [CORENUM];
    logic                 r_v1;
    logic signed [SW-1:0] r_sum;
    logic                 r_v2;
    logic signed [W-1:0]  r_acc;
    logic [W-1:0]         r_count;
    logic                 r_sat;

    logic signed [SW-1:0] w_sum;
    logic signed [XW-1:0] w_acc_wide;
    logic                 w_over;
    logic                 w_under;
    logic signed [W-1:0]  w_acc_sat;

    // Stage 1: map each strobed lane to +1/-1 (0 when not strobed)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CORENUM; k++) begin
                r_sel[k] <= 2'sd0;
            end
            r_v1 <= 1'b0;
        end else begin
            for (int k = 0; k < CORENUM; k++) begin
                r_sel[k] <= bus.store[k] ? (bus.core_result[k] ? 2'sd1 : -2'sd1) : 2'sd0;
            end
            r_v1 <= |bus.store;
        end
    end

    // Signed sum of all lane contributions
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < CORENUM; k++) begin
            w_sum = w_sum + SW'(r_sel[k]);
        end
    end

    // Stage 2: register the lane sum; clear discards what stage 1 held
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_sum <= '0;
            r_v2  <= 1'b0;
        end else begin
            r_sum <= w_sum;
            r_v2  <= r_v1;
        end
    end

    // Saturating add of the lane sum onto the accumulator
    always_comb begin
        w_acc_wide = XW'(r_acc) + XW'(r_sum);
        w_over     = (w_acc_wide > c_ACC_MAX);
        w_under    = (w_acc_wide < c_ACC_MIN);
        if (w_over) begin
            w_acc_sat = c_ACC_MAX[W-1:0];
        end else if (w_under) begin
            w_acc_sat = c_ACC_MIN[W-1:0];
        end else begin
            w_acc_sat = w_acc_wide[W-1:0];
        end
    end

    // Stage 3: accumulate, count accepted cycles, latch the sticky clamp flag
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_acc   <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (r_v2) begin
            r_acc <= w_acc_sat;
            if (r_count != c_CNT_MAX) begin
                r_count <= r_count + 1'b1;
            end
            if (w_over || w_under) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign bus.acc_value   = r_acc;
    assign bus.store_count = r_count;
    assign bus.busy        = r_v1 | r_v2;
    assign bus.sat_flag    = r_sat;

`ifdef BUNDLE_TIE_BREAK_EN
    // A zero accumulator is a tie; let the external tie source decide
    assign bus.sign_bit = (r_acc == '0) ? bus.tie_bit : r_acc[W-1];
`else
    logic w_tie_unused;
    assign w_tie_unused = bus.tie_bit;
    assign bus.sign_bit = r_acc[W-1];
`endif
endmodule
`default_nettype wire
